// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types and constants for the two-master RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int c_ADDR_W_DEF    = 6;
    localparam int c_DATA_W_DEF    = 32;
    localparam int c_MAX_BURST_DEF = 4;

    // Read data comes back two cycles after the transfer: one cycle to
    // register the command into the RAM, one for the RAM's synchronous read.
    localparam int c_PIPE_DEPTH    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arbState_e;

    typedef struct packed {
        logic valid;
        logic id;
    } rdTag_t;

    // Burst counter only has to reach MAX_BURST-1, but never collapses to
    // zero bits when MAX_BURST is 1.
    function automatic int burstCntWidth(input int maxBurst);
        return (maxBurst > 1) ? $clog2(maxBurst) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arb_rdpipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_rdpipe
// Brief    : Shift register of {valid,id} read tags; the last stage lines up
//            with RAM read data and is decoded into per-master strobes.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arb_rdpipe
    import ram_arb_pkg::*;
(
    input  logic clka,
    input  logic rsta,
    input  logic pushValid,
    input  logic pushId,
    output logic rvalid0,
    output logic rvalid1
);

    rdTag_t r_stage [c_PIPE_DEPTH];

    // First stage captures the tag of the read transfer happening this cycle.
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_stage[0] <= '0;
        end else begin
            r_stage[0].valid <= pushValid;
            r_stage[0].id    <= pushId;
        end
    end

    generate
        for (genvar gi = 1; gi < c_PIPE_DEPTH; gi++) begin : g_stage
            // Each later stage follows its predecessor; reset drops in-flight reads.
            always_ff @(posedge clka) begin
                if (rsta) begin
                    r_stage[gi] <= '0;
                end else begin
                    r_stage[gi] <= r_stage[gi-1];
                end
            end
        end
    endgenerate

    assign rvalid0 = r_stage[c_PIPE_DEPTH-1].valid & ~r_stage[c_PIPE_DEPTH-1].id;
    assign rvalid1 = r_stage[c_PIPE_DEPTH-1].valid &  r_stage[c_PIPE_DEPTH-1].id;

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Round-robin, burst-bounded arbiter giving two masters access to
//            a single-port synchronous RAM; tags read returns per master.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W_DEF,
    parameter int DATA_W    = c_DATA_W_DEF,
    parameter int MAX_BURST = c_MAX_BURST_DEF
)
(
    input  logic              clka,
    input  logic              rsta,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_wea,
    input  logic [DATA_W-1:0] ram_douta
);

    localparam int                 c_CNT_W    = burstCntWidth(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_BURST - 1);

    arbState_e          r_state;
    logic               r_m0Gnt;
    logic               r_m1Gnt;
    logic               r_last;
    logic [c_CNT_W-1:0] r_burstCnt;

    logic [ADDR_W-1:0]  r_ramAddr;
    logic [DATA_W-1:0]  r_ramDin;
    logic               r_ramWe;

    logic               w_ownReq;
    logic               w_otherReq;
    logic               w_ownerId;
    logic               w_ownerWe;
    logic [ADDR_W-1:0]  w_ownerAddr;
    logic [DATA_W-1:0]  w_ownerData;
    arbState_e          w_otherState;
    logic               w_xfer;

    // Select the current owner's command fields and the competing request.
    always_comb begin
        w_ownReq     = 1'b0;
        w_otherReq   = 1'b0;
        w_ownerId    = 1'b0;
        w_ownerWe    = m0_we;
        w_ownerAddr  = m0_addr;
        w_ownerData  = m0_wdata;
        w_otherState = OWN1;
        case (r_state)
            OWN0: begin
                w_ownReq     = m0_req;
                w_otherReq   = m1_req;
                w_otherState = OWN1;
            end
            OWN1: begin
                w_ownReq     = m1_req;
                w_otherReq   = m0_req;
                w_ownerId    = 1'b1;
                w_ownerWe    = m1_we;
                w_ownerAddr  = m1_addr;
                w_ownerData  = m1_wdata;
                w_otherState = OWN0;
            end
            default: ;
        endcase
    end

    assign w_xfer = (r_m0Gnt & m0_req) | (r_m1Gnt & m1_req);

    // Ownership FSM with registered grants, burst counter and last-owner pointer.
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_state    <= IDLE;
            r_m0Gnt    <= 1'b0;
            r_m1Gnt    <= 1'b0;
            r_last     <= 1'b1;
            r_burstCnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // On a tie the master that did not own last goes first.
                    if (m0_req && (!m1_req || r_last)) begin
                        r_state <= OWN0;
                        r_m0Gnt <= 1'b1;
                    end else if (m1_req) begin
                        r_state <= OWN1;
                        r_m1Gnt <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (w_ownReq) begin
                        if (r_burstCnt != c_CNT_LAST) begin
                            r_burstCnt <= r_burstCnt + 1'b1;
                        end else if (w_otherReq) begin
                            // Burst exhausted: hand over with no dead cycle.
                            r_state    <= w_otherState;
                            r_m0Gnt    <= w_ownerId;
                            r_m1Gnt    <= ~w_ownerId;
                            r_last     <= w_ownerId;
                            r_burstCnt <= '0;
                        end
                        // Otherwise the other side is idle: keep the bus, count saturated.
                    end else begin
                        r_last     <= w_ownerId;
                        r_burstCnt <= '0;
                        if (w_otherReq) begin
                            r_state <= w_otherState;
                            r_m0Gnt <= w_ownerId;
                            r_m1Gnt <= ~w_ownerId;
                        end else begin
                            r_state <= IDLE;
                            r_m0Gnt <= 1'b0;
                            r_m1Gnt <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_m0Gnt    <= 1'b0;
                    r_m1Gnt    <= 1'b0;
                    r_burstCnt <= '0;
                end
            endcase
        end
    end

    // RAM command registers: loaded on a transfer, write enable pulses for one cycle.
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_ramAddr <= '0;
            r_ramDin  <= '0;
            r_ramWe   <= 1'b0;
        end else if (w_xfer) begin
            r_ramAddr <= w_ownerAddr;
            r_ramDin  <= w_ownerData;
            r_ramWe   <= w_ownerWe;
        end else begin
            r_ramWe   <= 1'b0;
        end
    end

    ram_arb_rdpipe u_rdpipe (
        .clka      (clka),
        .rsta      (rsta),
        .pushValid (w_xfer & ~w_ownerWe),
        .pushId    (w_ownerId),
        .rvalid0   (m0_rvalid),
        .rvalid1   (m1_rvalid)
    );

    assign m0_gnt    = r_m0Gnt;
    assign m1_gnt    = r_m1Gnt;
    assign m0_rdata  = ram_douta;
    assign m1_rdata  = ram_douta;
    assign ram_addra = r_ramAddr;
    assign ram_dina  = r_ramDin;
    assign ram_wea   = r_ramWe;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed bench for ram_arbiter with a behavioural RAM, a
//            transaction-level reference model and a per-cycle comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    logic              clka = 1'b0;
    logic              rsta;
    logic              m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic [ADDR_W-1:0] ram_addra;
    logic [DATA_W-1:0] ram_dina, ram_douta;
    logic              ram_wea;

    always #5 clka = ~clka;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clka(clka), .rsta(rsta),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
        .ram_douta(ram_douta)
    );

    // Behavioural single-port synchronous RAM.
    logic [DATA_W-1:0] ramMem [64];
    always @(posedge clka) begin
        if (ram_wea) ramMem[ram_addra] <= ram_dina;
        ram_douta <= ramMem[ram_addra];
    end

    int nCmp  = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: ownership, expected RAM command, expected returns
    // ------------------------------------------------------------------
    int                mOwner;     // -1 idle, else owning master
    int                mCnt;       // transfers in the current tenure
    bit                mLast;
    bit                modelOn = 1'b0;
    bit                eWe;
    logic [ADDR_W-1:0] eAddr;
    logic [DATA_W-1:0] eDin;
    bit                pV  [2];
    bit                pId [2];
    logic [DATA_W-1:0] pD  [2];
    logic [DATA_W-1:0] shadow [64];
    bit                sReq [2];
    bit                sWe  [2];
    logic [ADDR_W-1:0] sAd  [2];
    logic [DATA_W-1:0] sWd  [2];

    always @(posedge clka) begin
        sReq[0] = m0_req; sWe[0] = m0_we; sAd[0] = m0_addr; sWd[0] = m0_wdata;
        sReq[1] = m1_req; sWe[1] = m1_we; sAd[1] = m1_addr; sWd[1] = m1_wdata;
        if (rsta) begin
            mOwner = -1; mLast = 1'b1; mCnt = 0;
            eWe = 1'b0; eAddr = '0; eDin = '0;
            pV[0] = 1'b0; pV[1] = 1'b0;
            modelOn = 1'b1;
        end else if (modelOn) begin
            pV[1] = pV[0]; pId[1] = pId[0]; pD[1] = pD[0];
            pV[0] = 1'b0;
            eWe   = 1'b0;
            if (mOwner >= 0 && sReq[mOwner]) begin
                eWe   = sWe[mOwner];
                eAddr = sAd[mOwner];
                eDin  = sWd[mOwner];
                if (sWe[mOwner]) shadow[eAddr] = eDin;
                else begin
                    pV[0] = 1'b1; pId[0] = mOwner[0]; pD[0] = shadow[eAddr];
                end
                mCnt++;
                if (mCnt >= MAX_BURST && sReq[1-mOwner]) begin
                    mLast = mOwner[0]; mOwner = 1 - mOwner; mCnt = 0;
                end
            end else if (mOwner >= 0) begin
                mLast  = mOwner[0];
                mOwner = sReq[1-mOwner] ? 1 - mOwner : -1;
                mCnt   = 0;
            end else begin
                if (sReq[0] && sReq[1]) mOwner = mLast ? 0 : 1;
                else if (sReq[0])       mOwner = 0;
                else if (sReq[1])       mOwner = 1;
            end
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clka) begin
        if (modelOn) begin
            check("gnt0",    32'(m0_gnt),    32'(mOwner == 0));
            check("gnt1",    32'(m1_gnt),    32'(mOwner == 1));
            check("ram_wea", 32'(ram_wea),   32'(eWe));
            check("ram_addra", 32'(ram_addra), 32'(eAddr));
            check("ram_dina",  ram_dina,       eDin);
            check("rvalid0", 32'(m0_rvalid), 32'(pV[1] && !pId[1]));
            check("rvalid1", 32'(m1_rvalid), 32'(pV[1] &&  pId[1]));
            if (pV[1]) begin
                if (pId[1]) check("rdata1", m1_rdata, pD[1]);
                else        check("rdata0", m0_rdata, pD[1]);
            end
        end
    end

    // Activity log taken from the DUT pins, used by the literal checks.
    int                cyc = 0;
    int                xOwn[$];
    int                xCyc[$];
    int                weCnt = 0;
    int                lastWeAddr = 0;
    int                rv0Cnt = 0;
    int                rv1Cnt = 0;
    int                rv0Cyc[$];
    logic [DATA_W-1:0] lastRd0 = '0;

    always @(negedge clka) begin
        cyc++;
        if (m0_req === 1'b1 && m0_gnt === 1'b1) begin xOwn.push_back(0); xCyc.push_back(cyc); end
        if (m1_req === 1'b1 && m1_gnt === 1'b1) begin xOwn.push_back(1); xCyc.push_back(cyc); end
        if (ram_wea === 1'b1) begin weCnt++; lastWeAddr = int'(ram_addra); end
        if (m0_rvalid === 1'b1) begin rv0Cnt++; rv0Cyc.push_back(cyc); lastRd0 = m0_rdata; end
        if (m1_rvalid === 1'b1) rv1Cnt++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    op_t q0[$];
    op_t q1[$];

    function automatic op_t mkOp(input logic we, input int addr, input logic [31:0] data);
        op_t o;
        o.we = we; o.addr = ADDR_W'(addr); o.data = data;
        return o;
    endfunction

    task automatic setMaster(input int idx, input logic req, input op_t op);
        if (idx == 0) begin
            m0_req = req; m0_we = op.we; m0_addr = op.addr; m0_wdata = op.data;
        end else begin
            m1_req = req; m1_we = op.we; m1_addr = op.addr; m1_wdata = op.data;
        end
    endtask

    // Issue the queued ops of one master, advancing after each granted transfer.
    task automatic runMaster(input int idx);
        op_t op;
        int  guard;
        guard = 0;
        op    = '0;
        while (((idx == 0) ? q0.size() : q1.size()) > 0) begin
            op = (idx == 0) ? q0[0] : q1[0];
            setMaster(idx, 1'b1, op);
            @(negedge clka);
            if (((idx == 0) ? m0_gnt : m1_gnt) === 1'b1) begin
                if (idx == 0) void'(q0.pop_front());
                else          void'(q1.pop_front());
            end
            guard++;
            if (guard > 2000) begin
                check("runMaster_timeout", 32'(guard), 32'd0);
                if (idx == 0) q0.delete(); else q1.delete();
            end
            @(posedge clka); #1;
        end
        setMaster(idx, 1'b0, op);
    endtask

    task automatic waitGnt(input int idx);
        int guard;
        guard = 0;
        forever begin
            @(negedge clka);
            if (((idx == 0) ? m0_gnt : m1_gnt) === 1'b1) break;
            guard++;
            if (guard > 50) begin
                check("waitGnt_timeout", 32'(guard), 32'd0);
                break;
            end
            @(posedge clka); #1;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clka);
        #1;
    endtask

    task automatic doReset();
        rsta = 1'b1;
        @(posedge clka); #1;
        rsta = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r0s, r1s, ws, rcs;

        // ---- 1: reset with random master inputs --------------------------
        rsta = 1'b1;
        setMaster(0, 1'($urandom), op_t'($urandom));
        setMaster(1, 1'($urandom), op_t'({$urandom, $urandom}));
        @(posedge clka); #1;
        setMaster(0, 1'b1, op_t'({$urandom, $urandom}));
        setMaster(1, 1'b1, op_t'({$urandom, $urandom}));
        @(posedge clka); #1;
        rsta = 1'b0;
        setMaster(0, 1'b0, '0);
        setMaster(1, 1'b0, '0);
        @(negedge clka);
        check("rst_gnt0",    32'(m0_gnt),    32'd0);
        check("rst_gnt1",    32'(m1_gnt),    32'd0);
        check("rst_wea",     32'(ram_wea),   32'd0);
        check("rst_addra",   32'(ram_addra), 32'd0);
        check("rst_dina",    ram_dina,       32'd0);
        check("rst_rvalid0", 32'(m0_rvalid), 32'd0);
        check("rst_rvalid1", 32'(m1_rvalid), 32'd0);
        @(posedge clka); #1;

        // ---- 2: single master write then read ----------------------------
        ws = weCnt; r0s = rv0Cnt; r1s = rv1Cnt;
        q0.push_back(mkOp(1'b1, 5, 32'hDEADBEEF));
        q0.push_back(mkOp(1'b0, 5, 32'h0));
        runMaster(0);
        idleCycles(4);
        check("t2_wea_cycles", 32'(weCnt - ws),    32'd1);
        check("t2_wea_addr",   32'(lastWeAddr),    32'd5);
        check("t2_rv0_count",  32'(rv0Cnt - r0s),  32'd1);
        check("t2_rv1_count",  32'(rv1Cnt - r1s),  32'd0);
        check("t2_rdata",      lastRd0,            32'hDEADBEEF);
        check("t2_latency",    32'(rv0Cyc[rv0Cyc.size()-1] - xCyc[xCyc.size()-1]), 32'd2);

        // ---- 4: m1 fills, m0 reads back ----------------------------------
        for (int i = 0; i < 64; i++) q1.push_back(mkOp(1'b1, i, 32'(i + 32'h100)));
        runMaster(1);
        r0s = rv0Cnt; rcs = rv0Cyc.size();
        for (int i = 0; i < 64; i++) q0.push_back(mkOp(1'b0, i, 32'h0));
        runMaster(0);
        idleCycles(4);
        check("t4_rv0_count", 32'(rv0Cnt - r0s), 32'd64);
        if (rv0Cyc.size() >= rcs + 64)
            check("t4_back2back", 32'(rv0Cyc[rcs+63] - rv0Cyc[rcs]), 32'd63);
        else
            check("t4_back2back_len", 32'(rv0Cyc.size() - rcs), 32'd64);
        check("t4_rdata63", lastRd0, 32'h13F);

        // ---- 3: tie from reset, continuous reads, bounded bursts ---------
        doReset();
        s = xOwn.size();
        for (int i = 0; i < 20; i++) begin
            q0.push_back(mkOp(1'b0, i, 32'h0));
            q1.push_back(mkOp(1'b0, 32 + i, 32'h0));
        end
        fork
            runMaster(0);
            runMaster(1);
        join
        idleCycles(4);
        check("t3_xfer_total", 32'(xOwn.size() - s), 32'd40);
        if (xOwn.size() >= s + 40) begin
            for (int k = 0; k < 40; k++)
                check("t3_owner_seq", 32'(xOwn[s+k]), 32'((k / 4) % 2));
            check("t3_no_gap", 32'(xCyc[s+39] - xCyc[s]), 32'd39);
        end

        // ---- 5: reset lands the cycle after a read transfer --------------
        r0s = rv0Cnt;
        setMaster(0, 1'b1, mkOp(1'b0, 16, 32'h0));
        waitGnt(0);
        @(posedge clka); #1;
        setMaster(0, 1'b0, mkOp(1'b0, 16, 32'h0));
        rsta = 1'b1;
        @(posedge clka); #1;
        rsta = 1'b0;
        @(negedge clka);
        check("t5_rvalid0", 32'(m0_rvalid), 32'd0);
        check("t5_gnt0",    32'(m0_gnt),    32'd0);
        check("t5_gnt1",    32'(m1_gnt),    32'd0);
        idleCycles(3);
        check("t5_rv0_count", 32'(rv0Cnt - r0s), 32'd0);

        // ---- 6: owner m1 drops req while m0 waits ------------------------
        setMaster(1, 1'b1, mkOp(1'b0, 1, 32'h0));
        waitGnt(1);
        @(posedge clka); #1;
        setMaster(1, 1'b0, mkOp(1'b0, 1, 32'h0));
        setMaster(0, 1'b1, mkOp(1'b0, 2, 32'h0));
        @(negedge clka);
        check("t6_dead_gnt1", 32'(m1_gnt), 32'd1);
        check("t6_dead_gnt0", 32'(m0_gnt), 32'd0);
        @(posedge clka); #1;
        @(negedge clka);
        check("t6_gnt0", 32'(m0_gnt), 32'd1);
        @(posedge clka); #1;
        setMaster(0, 1'b0, mkOp(1'b0, 2, 32'h0));
        idleCycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

- Two-requester arbiter sharing the single-port 64×32 `Memoria_RAM` between two masters, e.g. CPU data port and a loader/DMA.
- Owns the RAM's `addra`/`dina`/`wea` inputs and registers every accepted command into them.
- Returns read data with a fixed latency and tags it to the issuing master.
- Round-robin, with a bounded burst so neither master starves.

## Interface
- `ADDR_W`, 6, RAM address width (64 words)
- `DATA_W`, 32, RAM data width
- `MAX_BURST`, 4, max consecutive transfers by one owner while the other requests (≥1)

- `clka` in 1 — single clock, rising edge
- `rsta` in 1 — reset, synchronous, active-high
- `mN_req` in 1 — master N (N=0,1) request; command fields valid while high
- `mN_we` in 1 — 1 = write, 0 = read
- `mN_addr` in ADDR_W — word address
- `mN_wdata` in DATA_W — write data
- `mN_gnt` out 1 — registered grant; transfer = `mN_req & mN_gnt`
- `mN_rvalid` out 1 — read data valid for master N, one cycle per read
- `mN_rdata` out DATA_W — equals `ram_douta`; meaningful only when `mN_rvalid` is high
- `ram_addra` out ADDR_W — to RAM `addra`
- `ram_dina` out DATA_W — to RAM `dina`
- `ram_wea` out 1 — to RAM `wea`
- `ram_douta` in DATA_W — from RAM `douta`; RAM read is synchronous, data valid the cycle after `addra` is sampled

## Operation
**FSM states:** IDLE, OWN0, OWN1. `m0_gnt`=1 only in OWN0 and `m1_gnt`=1 only in OWN1; both grants are 0 in IDLE.

**`last` pointer**
- 1 bit; records the most recent owner.
- Reset value 1, so m0 wins the first tie.

**IDLE**
- Only m0 requests → OWN0.
- Only m1 requests → OWN1.
- Both request → OWN(~last).
- Neither → stay in IDLE.

**OWNn, owner still requesting**
- Each cycle with `req&gnt` is a transfer; it increments `burst_cnt`.
- The transfer that brings the count to MAX_BURST, with the other master requesting → switch to the other master's OWN state, `last`←n, `burst_cnt`←0.
- Other master idle → stay in OWNn; `burst_cnt` saturates at MAX_BURST−1.

**OWNn, owner drops `req`**
- That cycle is not a transfer.
- Other master requesting → go to its OWN state; otherwise → IDLE.
- In both cases `last`←n and `burst_cnt`←0.

**Transfer in cycle T**
- At the T edge, `ram_addra`/`ram_dina`/`ram_wea` are loaded from the owner's fields.
- Outside transfers, `ram_wea`←0 and the address/data registers hold their last value.
- A read pushes `{valid=1, id=n}` into a 2-stage tag pipe.

**Read return**
- Stage 2 of the pipe drives `mN_rvalid` for the matching id.
- Writes never produce `rvalid`.

**Masters**
- Must hold their command fields stable while `req` is high and no transfer has yet occurred.
- May change fields every cycle once transfers are occurring.

## Timing
**Reset values (cycle after an `rsta`-high edge)**
- State IDLE, both `gnt`=0.
- `ram_wea`=0, `ram_addra`=0, `ram_dina`=0.
- Both `rvalid`=0, tag pipe cleared, `burst_cnt`=0, `last`=1.

**Latencies**
- Request from IDLE: `req` seen at edge E → `gnt` high the cycle after E. First transfer is at the earliest one cycle after `req` rises.
- Transfer in cycle T: RAM inputs are valid in T+1 and sampled at the end of T+1.
- Read transfer in cycle T: `mN_rvalid` and `mN_rdata` are valid in T+2.
- Back-to-back transfers sustain 1 per cycle with pipelined reads, across owner switches.

**Boundary conditions**
- Ownership handover: the switch costs zero cycles on a MAX_BURST expiry and one dead cycle on a `req` drop.
- Read-after-write to the same address in consecutive cycles: the read returns the new data, because the RAM write completes before the read is sampled.
- Address 63 is accepted like any other; the arbiter does no wrap and no range check.
- `rsta` asserted mid-operation: in-flight reads are discarded with no `rvalid`, and pending requests must re-arbitrate from IDLE.
- MAX_BURST=1: strict alternation whenever both masters request.

## Structure
- **Package `ram_arb_pkg`:** state enum (IDLE/OWN0/OWN1), default widths, tag-pipe depth constant (2), and the `burst_cnt` width `$clog2(MAX_BURST)` (min 1).
- **Sub-module `ram_arb_rdpipe`:** the 2-stage `{valid,id}` shift register with synchronous clear, producing the two `rvalid` strobes.
- **Top level:** FSM, counter, `last` pointer, and RAM command registers.

## Test plan
1. **Reset:** hold `rsta` 2 cycles with random master inputs → every output listed under Timing at its reset value; no `gnt`.
2. **Single master:** m0 writes 0xDEADBEEF to 0x05, then reads 0x05 →
   - `ram_wea`=1, `ram_addra`=0x05 for exactly one cycle;
   - `m0_rvalid` in T+2 with `m0_rdata`=0xDEADBEEF;
   - `m1_rvalid` stays 0.
3. **Tie and fairness:** both request from reset with continuous reads, MAX_BURST=4 →
   - first grant to m0;
   - exactly 4 transfers per owner, then a zero-gap handover;
   - no transfer dropped or duplicated over 40 cycles.
4. **Fill and readback:** m1 writes data=addr+0x100 to addresses 0..63; m0 then reads 0..63 back-to-back → 64 `rvalid`s in consecutive cycles, all matching, including address 63.
5. **Reset mid-read:** `rsta` high in cycle T+1 after a read transfer in T → no `rvalid` in T+2; state IDLE afterwards.
6. **Req drop:** owner m1 drops `req` while m0 requests → one dead cycle, then `m0_gnt`=1 and `last`=1.
